// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   rx_state_t   : receiver deframing states
//   clks_per_bit : clock cycles per serial bit for a given clock/baud pair
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Integer divide; the caller is expected to keep the result at 4 or more
    // so that the half-bit start sample point is meaningful.
    function automatic int clks_per_bit(input int clock_speed, input int baud_rate);
        return clock_speed / baud_rate;
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// rx_byte_fifo
// Show-ahead circular FIFO with wrapping read/write pointers.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   push       : write push_data (dropped when full unless a pop happens too)
//   push_data  : byte to write
//   pop        : remove head entry (ignored when empty)
//   data       : current head entry
//   count      : number of stored entries
//   full/empty : occupancy status
// ---------------------------------------------------------------------------
module rx_byte_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic [DATA_WIDTH-1:0]               push_data,
    input  logic                                pop,
    output logic [DATA_WIDTH-1:0]               data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
    output logic                                full,
    output logic                                empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign data  = mem[rd_ptr];
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 serial receiver with a small show-ahead receive FIFO.
// Ports:
//   clk, rst    : clock, synchronous active-low reset
//   rtx         : asynchronous serial line, idle high
//   rd_en_i     : pop the head byte (ignored when valid_o is low)
//   clr_err_i   : clear both sticky error flags
//   data_o      : FIFO head byte
//   valid_o     : FIFO holds at least one byte
//   count_o     : FIFO occupancy
//   frame_err_o : sticky, a stop bit was sampled low
//   overrun_o   : sticky, a received byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BAUD_RATE   = 115200,
    parameter int CLOCK_SPEED = 100000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rtx,
    input  logic                                rd_en_i,
    input  logic                                clr_err_i,
    output logic [DATA_WIDTH-1:0]               data_o,
    output logic                                valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count_o,
    output logic                                frame_err_o,
    output logic                                overrun_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_SPEED, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic                  rx_meta;
    logic                  rx_s;
    rx_state_t             state;
    rx_state_t             state_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_next;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      bit_idx_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  byte_done;
    logic                  frame_set;
    logic                  overrun_set;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Two-flop synchronizer; resets to the idle line level so reset never
    // looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rtx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
        end
    end

    // The start bit is checked at its midpoint; from then on each full bit
    // period lands on the middle of the next bit. Leaving STOP at mid-stop-bit
    // gives half a bit of slack to catch a directly following start bit.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        byte_done    = 1'b0;
        frame_set    = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_next = '0;
                bit_idx_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_cnt == HALF_CNT) begin
                    bit_cnt_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_next = '0;
                    shift_next   = {rx_s, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_idx == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt_next = '0;
                    state_next   = IDLE;
                    if (rx_s) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A full FIFO always has a valid head, so rd_en_i alone means a real pop.
    assign overrun_set = byte_done && fifo_full && !rd_en_i;

    // Sticky flags: a new error in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err_o <= 1'b1;
            end else if (clr_err_i) begin
                frame_err_o <= 1'b0;
            end
            if (overrun_set) begin
                overrun_o <= 1'b1;
            end else if (clr_err_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    rx_byte_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (byte_done),
        .push_data(shift_reg),
        .pop      (rd_en_i),
        .data     (data_o),
        .count    (count_o),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign valid_o = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo at 16 clocks per bit. Expected FIFO
// contents and flags come from a byte queue plus two flag bits kept here.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CLOCK_SPEED = 1600;
    localparam int BAUD_RATE   = 100;
    localparam int CPB         = CLOCK_SPEED / BAUD_RATE;
    localparam int DEPTH       = 4;
    // Stop bit sampled 2 + CPB/2 + 9*CPB clocks after rtx falls; outputs
    // show the new byte one edge later.
    localparam int PUSH_EDGE   = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rtx;
    logic       rd_en_i;
    logic       clr_err_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic [2:0] count_o;
    logic       frame_err_o;
    logic       overrun_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_q[$];
    logic       model_frame;
    logic       model_overrun;

    uart_rx_fifo #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (BAUD_RATE),
        .CLOCK_SPEED(CLOCK_SPEED),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rtx        (rtx),
        .rd_en_i    (rd_en_i),
        .clr_err_i  (clr_err_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .count_o    (count_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    // Drives one 8N1 character starting at the next falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rtx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rtx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rtx = stop_bit;
        repeat (CPB) @(negedge clk);
        rtx = 1'b1;
    endtask

    task automatic model_send(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit) begin
            model_frame = 1'b1;
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(b);
        end else begin
            model_overrun = 1'b1;
        end
    endtask

    task automatic pop_byte();
        @(negedge clk);
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
        if (model_q.size() > 0) begin
            void'(model_q.pop_front());
        end
    endtask

    task automatic clear_errors();
        @(negedge clk);
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
        model_frame   = 1'b0;
        model_overrun = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rtx = 1'b1;
        rd_en_i = 1'b0;
        clr_err_i = 1'b0;
        model_q.delete();
        model_frame = 1'b0;
        model_overrun = 1'b0;
        repeat (4) @(negedge clk);
        checks += 5;
        if (data_o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data: got %0h expected 0", data_o);
        end
        if (valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %0b expected 0", valid_o);
        end
        if (count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", count_o);
        end
        if (frame_err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_frame_err: got %0b expected 0", frame_err_o);
        end
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_overrun: got %0b expected 0", overrun_o);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clk);
                repeat (PUSH_EDGE - 1) @(negedge clk);
                checks++;
                if (valid_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL single_early_valid: got %0b expected 0", valid_o);
                end
                @(negedge clk);
                checks += 3;
                if (valid_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL single_valid: got %0b expected 1", valid_o);
                end
                if (data_o !== 8'hA5) begin
                    errors++;
                    $display("[TB] FAIL single_data: got %0h expected a5", data_o);
                end
                if (count_o !== 3'd1) begin
                    errors++;
                    $display("[TB] FAIL single_count: got %0d expected 1", count_o);
                end
            end
        join
        model_send(8'hA5, 1'b1);
        checks++;
        if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_flags: got %0b%0b expected 00", frame_err_o, overrun_o);
        end
        pop_byte();
        checks += 2;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_pop_valid: got %0b expected 0", valid_o);
        end
        if (count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL single_pop_count: got %0d expected 0", count_o);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rtx = 1'b0;
        repeat (4) @(negedge clk);
        rtx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks += 2;
        if (count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL glitch_count: got %0d expected 0", count_o);
        end
        if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_flags: got %0b%0b expected 00", frame_err_o, overrun_o);
        end
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0);
        model_send(8'h3C, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checks += 2;
        if (frame_err_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_err_set: got %0b expected 1", frame_err_o);
        end
        if (count_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL frame_err_count: got %0d expected 0", count_o);
        end
        clear_errors();
        checks++;
        if (frame_err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_err_clear: got %0b expected 0", frame_err_o);
        end
        send_frame(8'h55, 1'b1);
        model_send(8'h55, 1'b1);
        checks += 2;
        if (data_o !== 8'h55 || valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_err_next_data: got %0h/%0b expected 55/1", data_o, valid_o);
        end
        if (count_o !== 3'd1) begin
            errors++;
            $display("[TB] FAIL frame_err_next_count: got %0d expected 1", count_o);
        end
        pop_byte();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            model_send(8'(i), 1'b1);
        end
        checks += 2;
        if (count_o !== 3'd4) begin
            errors++;
            $display("[TB] FAIL overrun_count: got %0d expected 4", count_o);
        end
        if (overrun_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_flag: got %0b expected 1", overrun_o);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (data_o !== 8'(i) || valid_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL overrun_read%0d: got %0h/%0b expected %0h/1", i, data_o, valid_o, i);
            end
            pop_byte();
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_drained: got %0b expected 0", valid_o);
        end
        clear_errors();
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_clear: got %0b expected 0", overrun_o);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1);
            model_send(8'h10 + 8'(i), 1'b1);
        end
        fork
            send_frame(8'h14, 1'b1);
            begin
                @(negedge clk);
                repeat (PUSH_EDGE - 1) @(negedge clk);
                rd_en_i = 1'b1;
                @(negedge clk);
                rd_en_i = 1'b0;
            end
        join
        void'(model_q.pop_front());
        model_q.push_back(8'h14);
        checks += 2;
        if (count_o !== 3'd4) begin
            errors++;
            $display("[TB] FAIL simul_count: got %0d expected 4", count_o);
        end
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_overrun: got %0b expected 0", overrun_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_o !== model_q[0]) begin
                errors++;
                $display("[TB] FAIL simul_read%0d: got %0h expected %0h", i, data_o, model_q[0]);
            end
            pop_byte();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] partial;
        partial = 8'h9A;
        send_frame(8'h3C, 1'b0);
        send_frame(8'h21, 1'b1);
        send_frame(8'h22, 1'b1);
        @(negedge clk);
        rtx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rtx = partial[i];
            repeat (CPB) @(negedge clk);
        end
        rtx = partial[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (valid_o !== 1'b0 || count_o !== 3'd0 || data_o !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_fifo: got %0b/%0d/%0h expected 0/0/0", valid_o, count_o, data_o);
        end
        if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got %0b%0b expected 00", frame_err_o, overrun_o);
        end
        rtx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_q.delete();
        model_frame = 1'b0;
        model_overrun = 1'b0;
        repeat (CPB) @(negedge clk);
        send_frame(8'hE7, 1'b1);
        model_send(8'hE7, 1'b1);
        checks += 2;
        if (count_o !== 3'd1) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %0d expected 1", count_o);
        end
        if (data_o !== 8'hE7 || valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_data: got %0h/%0b expected e7/1", data_o, valid_o);
        end
        pop_byte();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         act;
        for (int n = 0; n < 24; n++) begin
            act = int'($urandom_range(0, 5));
            b = 8'($urandom);
            if (act <= 2) begin
                send_frame(b, 1'b1);
                model_send(b, 1'b1);
            end else if (act == 3) begin
                send_frame(b, 1'b0);
                model_send(b, 1'b0);
                repeat (CPB) @(negedge clk);
            end else if (act == 4) begin
                pop_byte();
            end else begin
                clear_errors();
            end
            checks += 4;
            if (count_o !== 3'(model_q.size()) || valid_o !== (model_q.size() > 0)) begin
                errors++;
                $display("[TB] FAIL random_count%0d: got %0d/%0b expected %0d", n, count_o, valid_o, model_q.size());
            end
            if (model_q.size() > 0 && data_o !== model_q[0]) begin
                errors++;
                $display("[TB] FAIL random_data%0d: got %0h expected %0h", n, data_o, model_q[0]);
            end
            if (frame_err_o !== model_frame) begin
                errors++;
                $display("[TB] FAIL random_frame%0d: got %0b expected %0b", n, frame_err_o, model_frame);
            end
            if (overrun_o !== model_overrun) begin
                errors++;
                $display("[TB] FAIL random_overrun%0d: got %0b expected %0b", n, overrun_o, model_overrun);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_simultaneous();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
